// File: rtl/mole_scheduler.sv
// Whack-a-mole game controller: picks holes and gap lengths from an upstream random
// source, lights one hole per round, and tracks hits, misses and game end.
module mole_scheduler #(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned GAP_MIN    = 2,
  parameter int unsigned UP_TICKS   = 6,
  parameter int unsigned MAX_MISSES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] rand_val,
  input  logic [7:0] btn,
  output logic [7:0] mole,
  output logic [7:0] score,
  output logic [3:0] misses,
  output logic       game_over,
  output logic       busy
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    UP   = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] prescaler_reg, prescaler_next;
  logic [3:0]    gap_cnt_reg, gap_cnt_next;
  logic [3:0]    up_cnt_reg, up_cnt_next;
  logic [2:0]    last_hole_reg, last_hole_next;
  logic [7:0]    mole_reg, mole_next;
  logic [7:0]    score_reg, score_next;
  logic [3:0]    misses_reg, misses_next;
  logic          game_over_reg, game_over_next;
  logic          busy_reg, busy_next;

  logic          tick;
  logic [3:0]    gap_load;
  logic [2:0]    hole_pick;
  logic [7:0]    hole_onehot;
  logic [7:0]    hit_vec;
  logic          hit;

  // A repeated hole is bumped to the next one so the same hole never lights twice in a row.
  assign hole_pick = (rand_val[2:0] == last_hole_reg) ? rand_val[2:0] + 3'd1 : rand_val[2:0];
  assign gap_load  = 4'(GAP_MIN) + {2'b00, rand_val[4:3]};
  assign tick      = (state_reg != IDLE) && (prescaler_reg == TICK_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_hole
      assign hole_onehot[gi] = (hole_pick == 3'(gi));
      assign hit_vec[gi]     = btn[gi] & mole_reg[gi];
    end
  endgenerate

  assign hit = |hit_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      prescaler_reg <= '0;
      gap_cnt_reg   <= '0;
      up_cnt_reg    <= '0;
      last_hole_reg <= '0;
      mole_reg      <= '0;
      score_reg     <= '0;
      misses_reg    <= '0;
      game_over_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      prescaler_reg <= prescaler_next;
      gap_cnt_reg   <= gap_cnt_next;
      up_cnt_reg    <= up_cnt_next;
      last_hole_reg <= last_hole_next;
      mole_reg      <= mole_next;
      score_reg     <= score_next;
      misses_reg    <= misses_next;
      game_over_reg <= game_over_next;
      busy_reg      <= busy_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    gap_cnt_next   = gap_cnt_reg;
    up_cnt_next    = up_cnt_reg;
    last_hole_next = last_hole_reg;
    mole_next      = mole_reg;
    score_next     = score_reg;
    misses_next    = misses_reg;
    game_over_next = game_over_reg;

    // Free-running across GAP/UP transitions; only IDLE holds it at zero.
    if (state_reg == IDLE || tick) begin
      prescaler_next = '0;
    end else begin
      prescaler_next = prescaler_reg + 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (start) begin
          score_next     = '0;
          misses_next    = '0;
          game_over_next = 1'b0;
          gap_cnt_next   = gap_load;
          state_next     = GAP;
        end
      end

      GAP: begin
        mole_next = '0;
        if (tick) begin
          if (gap_cnt_reg == 4'd1) begin
            mole_next      = hole_onehot;
            last_hole_next = hole_pick;
            up_cnt_next    = 4'(UP_TICKS);
            state_next     = UP;
          end else begin
            gap_cnt_next = gap_cnt_reg - 4'd1;
          end
        end
      end

      UP: begin
        // A hit takes priority over a timeout landing in the same cycle.
        if (hit) begin
          if (score_reg != 8'hFF) begin
            score_next = score_reg + 8'd1;
          end
          mole_next    = '0;
          gap_cnt_next = gap_load;
          state_next   = GAP;
        end else if (tick) begin
          if (up_cnt_reg == 4'd1) begin
            mole_next   = '0;
            misses_next = misses_reg + 4'd1;
            if (misses_next == 4'(MAX_MISSES)) begin
              game_over_next = 1'b1;
              state_next     = IDLE;
            end else begin
              gap_cnt_next = gap_load;
              state_next   = GAP;
            end
          end else begin
            up_cnt_next = up_cnt_reg - 4'd1;
          end
        end
      end

      default: begin
        state_next = IDLE;
        mole_next  = '0;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  assign mole      = mole_reg;
  assign score     = score_reg;
  assign misses    = misses_reg;
  assign game_over = game_over_reg;
  assign busy      = busy_reg;

endmodule
